// File: rtl/layer_4_maxpool_2x2_pkg.sv
// Shared definitions for the layer_4 2x2 max-pool: pixel width and the fp32 total-order key.
package layer_4_maxpool_2x2_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] FP32_SIGN_MASK = 32'h8000_0000;

    // Maps fp32 bit patterns onto unsigned integers with the same ordering (+0 ranks above -0).
    function automatic logic [DATA_WIDTH-1:0] fp32_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x ^ FP32_SIGN_MASK);
    endfunction

endpackage

// File: rtl/layer_4_maxpool_2x2_if.sv
// Pixel stream bundle between the conv stage, the max-pool and its consumer.
interface layer_4_maxpool_2x2_if;
    import layer_4_maxpool_2x2_pkg::*;

    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  last_out;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  last_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output last_out
    );

endinterface

// File: rtl/layer_4_maxpool_2x2_fp32_max2.sv
// Combinational fp32 maximum of two operands using the package order key.
module layer_4_maxpool_2x2_fp32_max2
    import layer_4_maxpool_2x2_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] max_o
);

    assign max_o = (fp32_key(a_i) >= fp32_key(b_i)) ? a_i : b_i;

endmodule

// File: rtl/layer_4_maxpool_2x2.sv
// Streaming 2x2 / stride-2 fp32 max-pool over one raster-ordered feature map channel.
module layer_4_maxpool_2x2
    import layer_4_maxpool_2x2_pkg::*;
#(
    parameter int IMG_SIZE = 104
)
(
    input  logic           Clk,
    input  logic           Rst,
    layer_4_maxpool_2x2_if.slave pool_if
);

    localparam int CW   = $clog2(IMG_SIZE);
    localparam int HALF = IMG_SIZE / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(IMG_SIZE - 1);

    if ((IMG_SIZE < 2) || (IMG_SIZE % 2 != 0)) begin : g_size_check
        $error("layer_4_maxpool_2x2: IMG_SIZE must be an even value >= 2");
    end

    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] hmax_q, hmax_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  last_out_q, last_out_d;

    logic [DATA_WIDTH-1:0] h_max;
    logic [DATA_WIDTH-1:0] v_max;
    logic [DATA_WIDTH-1:0] rowbuf_rd;
    logic [HW-1:0]         rowbuf_idx;
    logic                  rowbuf_we;

    // One pooled-column entry per pair of input columns; never reset, always written on an even row first.
    logic [DATA_WIDTH-1:0] rowbuf [HALF];

    assign rowbuf_idx = HW'(col_q >> 1);
    assign rowbuf_rd  = rowbuf[rowbuf_idx];

    always_ff @(posedge Clk) begin
        if (rowbuf_we && !Rst) begin
            rowbuf[rowbuf_idx] <= h_max;
        end
    end

    layer_4_maxpool_2x2_fp32_max2 u_hmax (
        .a_i   (hmax_q),
        .b_i   (pool_if.data_in),
        .max_o (h_max)
    );

    layer_4_maxpool_2x2_fp32_max2 u_vmax (
        .a_i   (rowbuf_rd),
        .b_i   (h_max),
        .max_o (v_max)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hmax_d      = hmax_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
        rowbuf_we   = 1'b0;

        if (pool_if.valid_in) begin
            if (!col_q[0]) begin
                hmax_d = pool_if.data_in;
            end else if (!row_q[0]) begin
                rowbuf_we = 1'b1;
            end else begin
                data_out_d  = v_max;
                valid_out_d = 1'b1;
                last_out_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
            end

            // Frame wrap flows straight into the next frame's pixel (0,0).
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hmax_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hmax_q      <= hmax_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign pool_if.data_out  = data_out_q;
    assign pool_if.valid_out = valid_out_q;
    assign pool_if.last_out  = last_out_q;

endmodule

// File: tb/tb_layer_4_maxpool_2x2.sv
// Directed self-checking bench for layer_4_maxpool_2x2: 4x4 hand-computed frames plus a
// 104x104 two-frame random run against a sign/magnitude fp32 reference.
module tb_layer_4_maxpool_2x2;

    localparam int BIG     = 104;
    localparam int BIG_PIX = BIG * BIG;
    localparam int BIG_OUT = (BIG / 2) * (BIG / 2);

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    layer_4_maxpool_2x2_if if4 ();
    layer_4_maxpool_2x2_if if104 ();

    layer_4_maxpool_2x2 #(.IMG_SIZE(4)) dut4 (
        .Clk     (Clk),
        .Rst     (Rst),
        .pool_if (if4)
    );

    layer_4_maxpool_2x2 #(.IMG_SIZE(BIG)) dut104 (
        .Clk     (Clk),
        .Rst     (Rst),
        .pool_if (if104)
    );

    always #5 Clk = ~Clk;

    logic [31:0] posVals [16] = '{
        32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
        32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
        32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
        32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000
    };
    logic [31:0] px4 [16];
    logic [31:0] exp4 [4];
    logic [31:0] bigFrame [2*BIG_PIX];

    // Reference max written in sign/magnitude terms, independent of the order-key trick.
    function automatic logic [31:0] refMax(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31] ? b : a;
        if (!a[31]) return (a[30:0] >= b[30:0]) ? a : b;
        return (a[30:0] <= b[30:0]) ? a : b;
    endfunction

    task automatic checkOutput(input string tag, input bit big, input bit expValid,
                               input logic [31:0] expData, input bit expLast);
        logic        obsValid;
        logic        obsLast;
        logic [31:0] obsData;
        obsValid = big ? if104.valid_out : if4.valid_out;
        obsLast  = big ? if104.last_out  : if4.last_out;
        obsData  = big ? if104.data_out  : if4.data_out;
        assertCount++;
        assert (obsValid === expValid) else begin
            failCount++;
            $error("[TB] FAIL %s valid_out: got %0b expected %0b", tag, obsValid, expValid);
        end
        assertCount++;
        assert (obsLast === expLast) else begin
            failCount++;
            $error("[TB] FAIL %s last_out: got %0b expected %0b", tag, obsLast, expLast);
        end
        if (expValid) begin
            assertCount++;
            assert (obsData === expData) else begin
                failCount++;
                $error("[TB] FAIL %s data_out: got %08h expected %08h", tag, obsData, expData);
            end
        end
    endtask

    task automatic checkReset(input string tag, input bit big);
        logic [31:0] obsData;
        obsData = big ? if104.data_out : if4.data_out;
        checkOutput(tag, big, 1'b0, 32'h0, 1'b0);
        assertCount++;
        assert (obsData === 32'h0) else begin
            failCount++;
            $error("[TB] FAIL %s data_out: got %08h expected 00000000", tag, obsData);
        end
    endtask

    task automatic driveInputs(input bit big, input bit v, input logic [31:0] d);
        if (big) begin
            if104.valid_in = v;
            if104.data_in  = d;
        end else begin
            if4.valid_in = v;
            if4.data_in  = d;
        end
    endtask

    task automatic applyStimulus(input bit big, input logic [31:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge Clk);
            driveInputs(big, 1'b0, 32'h0);
            @(posedge Clk);
            #1;
            checkOutput("gap_quiet", big, 1'b0, 32'h0, 1'b0);
        end
        @(negedge Clk);
        driveInputs(big, 1'b1, d);
        @(posedge Clk);
        #1;
    endtask

    task automatic idleCycle(input string tag, input bit big);
        @(negedge Clk);
        driveInputs(big, 1'b0, 32'h0);
        @(posedge Clk);
        #1;
        checkOutput(tag, big, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic runFrame4(input string tag, input bit gaps, input int npix);
        int r;
        int c;
        for (int i = 0; i < npix; i++) begin
            r = i / 4;
            c = i % 4;
            applyStimulus(1'b0, px4[i], gaps ? int'($urandom_range(0, 5)) : 0);
            if ((r % 2 == 1) && (c % 2 == 1))
                checkOutput(tag, 1'b0, 1'b1, exp4[(r/2)*2 + c/2], (r == 3) && (c == 3));
            else
                checkOutput(tag, 1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        int r;
        int c;
        int p;
        int base;
        int outCount;
        int lastCount;
        logic [31:0] w;
        logic [31:0] e;

        driveInputs(1'b0, 1'b0, 32'h0);
        driveInputs(1'b1, 1'b0, 32'h0);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checkReset("reset4", 1'b0);
        checkReset("reset104", 1'b1);
        @(negedge Clk);
        Rst = 1'b0;

        $display("[TB] test 1: 1.0..16.0 continuous");
        for (int i = 0; i < 16; i++) px4[i] = posVals[i];
        exp4 = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
        runFrame4("t1", 1'b0, 16);
        idleCycle("t1_tail", 1'b0);

        $display("[TB] test 2: -1.0..-16.0");
        for (int i = 0; i < 16; i++) px4[i] = posVals[i] | 32'h8000_0000;
        exp4 = '{32'hBF80_0000, 32'hC040_0000, 32'hC110_0000, 32'hC130_0000};
        runFrame4("t2", 1'b0, 16);

        $display("[TB] test 3: signed zeros and mixed negatives");
        px4 = '{32'h0000_0000, 32'h8000_0000, 32'hC0A0_0000, 32'hC000_0000,
                32'h8000_0000, 32'h8000_0000, 32'hC0E0_0000, 32'hC040_0000,
                32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'hC040_0000,
                32'h8000_0000, 32'h0000_0000, 32'h3FC0_0000, 32'h8000_0000};
        exp4 = '{32'h0000_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000};
        runFrame4("t3", 1'b0, 16);

        $display("[TB] test 4: test 1 with random gaps");
        for (int i = 0; i < 16; i++) px4[i] = posVals[i];
        exp4 = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
        runFrame4("t4", 1'b1, 16);
        idleCycle("t4_tail", 1'b0);

        $display("[TB] test 5: reset mid-frame then clean frame");
        runFrame4("t5_partial", 1'b0, 7);
        @(negedge Clk);
        driveInputs(1'b0, 1'b0, 32'h0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        checkReset("t5_reset", 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        idleCycle("t5_after_reset", 1'b0);
        runFrame4("t5_clean", 1'b0, 16);
        idleCycle("t5_tail", 1'b0);

        $display("[TB] test 6: 104x104 random, two back-to-back frames");
        for (int i = 0; i < 2*BIG_PIX; i++) begin
            w = $urandom;
            if (w[30:23] == 8'hFF) w[30] = 1'b0;
            bigFrame[i] = w;
        end
        outCount  = 0;
        lastCount = 0;
        for (int i = 0; i < 2*BIG_PIX; i++) begin
            base = (i / BIG_PIX) * BIG_PIX;
            p    = i % BIG_PIX;
            r    = p / BIG;
            c    = p % BIG;
            applyStimulus(1'b1, bigFrame[i], 0);
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e = refMax(refMax(bigFrame[base + (r-1)*BIG + c-1], bigFrame[base + (r-1)*BIG + c]),
                           refMax(bigFrame[base + r*BIG + c-1],     bigFrame[base + r*BIG + c]));
                checkOutput("t6_pixel", 1'b1, 1'b1, e, (r == BIG-1) && (c == BIG-1));
            end else begin
                checkOutput("t6_quiet", 1'b1, 1'b0, 32'h0, 1'b0);
            end
            if (if104.valid_out === 1'b1) outCount++;
            if (if104.last_out === 1'b1) lastCount++;
            if (p == BIG_PIX - 1) begin
                assertCount++;
                assert (outCount == BIG_OUT) else begin
                    failCount++;
                    $error("[TB] FAIL t6_out_count: got %0d expected %0d", outCount, BIG_OUT);
                end
                assertCount++;
                assert (lastCount == 1) else begin
                    failCount++;
                    $error("[TB] FAIL t6_last_count: got %0d expected 1", lastCount);
                end
                outCount  = 0;
                lastCount = 0;
            end
        end
        idleCycle("t6_tail", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
